// File: rtl/pe_mem_arbiter.sv
// pe_mem_arbiter: round-robin arbiter sharing one single-port data memory
// between NPROC processing elements. Grants and memory controls are
// registered (issue one cycle after arbitration). Read data comes back one
// cycle after issue.
// Optional build macro ARB_COALESCE_EN: eligible loads that target the same
// address as a winning load are granted together and served by one memory
// read (gnt/rvalid may then be multi-hot).
module pe_mem_arbiter #(
  parameter int NPROC = 2,
  parameter int AW    = 16,
  parameter int DW    = 16
) (
  input  logic                clk,
  input  logic                reset,
  input  logic [NPROC-1:0]    req,
  input  logic [NPROC-1:0]    we,
  input  logic [NPROC*AW-1:0] addr,
  input  logic [NPROC*DW-1:0] wdata,
  output logic [NPROC-1:0]    gnt,
  output logic [NPROC-1:0]    rvalid,
  output logic [DW-1:0]       rdata,
  output logic                mem_en,
  output logic                mem_we,
  output logic [AW-1:0]       mem_addr,
  output logic [DW-1:0]       mem_wdata,
  input  logic [DW-1:0]       mem_rdata,
  output logic                stall
);

  localparam int PW = (NPROC > 1) ? $clog2(NPROC) : 1;

  logic [NPROC-1:0][AW-1:0] addr_a;
  logic [NPROC-1:0][DW-1:0] wdata_a;
  logic [PW-1:0]            ptr, win, ptr_nxt;
  logic                     found;
  logic [NPROC-1:0]         elig, gmask;
  // vld_pipe[0]: access issued this cycle; vld_pipe[1]: load data returning
  logic [1:0]               vld_pipe;
  logic [DW-1:0]            rdata_q;

  assign addr_a  = addr;
  assign wdata_a = wdata;

  // A PE holding req while its grant is visible must not win again.
  assign elig = req & ~gnt;

  // First eligible PE scanning from ptr with wrap.
  always_comb begin : scan
    int idx;
    idx   = 0;
    found = 1'b0;
    win   = '0;
    for (int k = 0; k < NPROC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NPROC) idx = idx - NPROC;
      if (!found && elig[idx]) begin
        found = 1'b1;
        win   = PW'(idx);
      end
    end
  end

  // Set of PEs granted this cycle (winner, plus same-address loads if coalescing).
  always_comb begin
    gmask = '0;
    if (found) gmask[win] = 1'b1;
`ifdef ARB_COALESCE_EN
    if (found && !we[win]) begin
      for (int i = 0; i < NPROC; i++)
        if (elig[i] && !we[i] && (addr_a[i] == addr_a[win])) gmask[i] = 1'b1;
    end
`endif
  end

  // Next pointer: one past the last granted PE in scan order.
  always_comb begin : nxt
    int idx;
    idx     = 0;
    ptr_nxt = ptr;
    for (int k = 0; k < NPROC; k++) begin
      idx = int'(ptr) + k;
      if (idx >= NPROC) idx = idx - NPROC;
      if (gmask[idx]) ptr_nxt = (idx == NPROC - 1) ? '0 : PW'(idx + 1);
    end
  end

  // Issue, read-return tracking and pointer update.
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      ptr       <= '0;
      gnt       <= '0;
      rvalid    <= '0;
      vld_pipe  <= '0;
      mem_we    <= 1'b0;
      mem_addr  <= '0;
      mem_wdata <= '0;
      rdata_q   <= '0;
    end else begin
      gnt      <= gmask;
      vld_pipe <= {vld_pipe[0] & ~mem_we, found};
      rvalid   <= (vld_pipe[0] && !mem_we) ? gnt : '0;
      if (found) begin
        mem_we    <= we[win];
        mem_addr  <= addr_a[win];
        mem_wdata <= wdata_a[win];
        ptr       <= ptr_nxt;
      end else begin
        mem_we    <= 1'b0;
      end
      if (|rvalid) rdata_q <= mem_rdata;
    end
  end

  assign mem_en = vld_pipe[0];
  // Memory data is live during the return cycle; otherwise hold the last word.
  assign rdata  = (|rvalid) ? mem_rdata : rdata_q;
  assign stall  = (|elig) | (|gnt) | (|rvalid) | vld_pipe[1];

endmodule

// File: doc/pe_mem_arbiter.md
Name: pe_mem_arbiter

Overview:
- Round-robin arbiter that shares one single-port data memory between the NPROC processing elements of the SIMD array.
- Sits between the PE load/store stage and the shared memory macro.
- Serialises simultaneous load/store requests, returns read data to the owning PE, and drives a stall to the control unit while any request is outstanding.

Parameters:
NPROC, 2, number of requesting PEs (>=2)
AW, 16, memory address width
DW, 16, data word width

Ports:
clk  in  1  system clock, rising edge
reset  in  1  asynchronous, active-low reset
req  in  NPROC  per-PE access request, level; held until granted
we  in  NPROC  per-PE write enable (1=store, 0=load), valid with req
addr  in  NPROC*AW  per-PE address; PE i uses bits [(i+1)*AW-1 : i*AW]
wdata  in  NPROC*DW  per-PE store data, same packing as addr
gnt  out  NPROC  one-hot grant pulse, registered
rvalid  out  NPROC  one-hot read-data-valid pulse
rdata  out  DW  shared read data bus, qualified by rvalid
mem_en  out  1  memory access strobe
mem_we  out  1  memory write enable
mem_addr  out  AW  memory address
mem_wdata  out  DW  memory write data
mem_rdata  in  DW  memory read data, valid 1 cycle after mem_en with mem_we=0
stall  out  1  CU pipeline hold

Behaviour:
- Reset (reset=0, asynchronous): gnt=0, rvalid=0, rdata=0, mem_en=0, mem_we=0, mem_addr=0, mem_wdata=0. Round-robin pointer ptr=0. Pipeline valid bits cleared.
- Arbitration each cycle:
  - Eligible set E = req & ~gnt. A requester whose gnt is high this cycle is masked, so its held req is not granted twice.
  - Winner w = first index in E scanning ptr, ptr+1, ..., NPROC-1, 0, ..., ptr-1.
  - If E==0: no grant, ptr unchanged.
- Issue (registered, cycle N+1 after the arbitration cycle N):
  - gnt[w]=1 for exactly one cycle.
  - mem_en=1; mem_we=we[w]; mem_addr=addr slice w; mem_wdata=wdata slice w.
  - ptr <= (w+1) mod NPROC.
- Requester must deassert req (or present a new request) in the cycle after it sees gnt.
- Read return: for a load issued in cycle N+1, cycle N+2 has rvalid[w]=1 and rdata=mem_rdata. Total load latency is 2 cycles from arbitration.
- Store: no rvalid; complete at issue.
- Throughput: one access per cycle; back-to-back grants to different PEs allowed.
- rdata holds its last value when rvalid=0.
- stall = (|E) | (|gnt) | (|rvalid) | pending-load. Combinational, high from the first req cycle until the last rvalid/store issue completes.
- Boundaries:
  - All NPROC requesting simultaneously: served in order ptr, ptr+1, ... over NPROC consecutive cycles. No requester waits more than NPROC cycles.
  - Single requester repeatedly toggling req: granted on alternate cycles at most.
  - req on a PE with we=1 and a same-cycle read from another PE to the same address: order strictly by grant order.
  - Reset asserted mid-operation: in-flight accesses are dropped, no rvalid is produced, ptr returns to 0.
  - ptr wraps from NPROC-1 to 0.

Optional Feature:
- Macro ARB_COALESCE_EN.
- Defined:
  - At arbitration, every eligible requester with we=0 and addr equal to the winner's addr, where the winner is also a load, is granted in the same cycle. gnt and rvalid may then be multi-hot.
  - One memory read serves all; rdata is broadcast.
  - ptr <= (highest-index coalesced requester after w in scan order + 1) mod NPROC.
  - Stores are never coalesced.
- Undefined: gnt and rvalid are strictly one-hot. Same-address loads are serialised normally.

Test Plan:
- Reset mid-read: PE0 load addr 0x0010 granted, reset=0 before rvalid -> rvalid stays 0, all outputs 0, ptr=0 after release.
- Single load: req=01, we=0, addr0=0x0040, mem holds 0x1234 -> gnt=01 at N+1 with mem_addr=0x0040; rvalid=01 and rdata=0x1234 at N+2; stall high cycles N..N+2.
- Contention: req=11 both loads, addr0=0x0005, addr1=0x0006, ptr=0 -> gnt=01 then gnt=10 on consecutive cycles; rvalid=01 then rvalid=10 with respective data.
- Fairness: req=11 held continuously (re-requesting after each grant) for 8 cycles -> grants alternate 01,10,01,10; no PE is granted twice in a row.
- Store then load same address: PE0 store 0xBEEF to 0x0100 (ptr=0), PE1 load 0x0100 -> store issues first; PE1 rdata=0xBEEF.
- ARB_COALESCE_EN: req=11, both loads to 0x0020 holding 0x00AA -> single mem_en cycle, gnt=11, rvalid=11, rdata=0x00AA. Without the macro: two accesses.
